// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem read port and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        misalign,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam int NUM_HALT_WORDS = 2;
    // ECALL and EBREAK: fetching either parks the front end.
    localparam logic [NUM_HALT_WORDS-1:0][31:0] HALT_WORDS = {32'h0010_0073, 32'h0000_0073};

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_inst_reg, ifid_inst_next;
    logic        misalign_reg, misalign_next;
    logic        fetch_load;

    logic [NUM_HALT_WORDS-1:0] halt_hit;
    logic                      is_halt_word;

    generate
        for (genvar gi = 0; gi < NUM_HALT_WORDS; gi++) begin : g_halt_match
            assign halt_hit[gi] = (imem_rdata == HALT_WORDS[gi]);
        end
    endgenerate

    assign is_halt_word = |halt_hit;

    // Priority: redirect > stall > halt > normal fetch (reset handled in the register).
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_inst_next  = ifid_inst_reg;
        misalign_next   = 1'b0;
        fetch_load      = 1'b0;

        if (redirect_valid) begin
            pc_next         = {redirect_pc[31:2], 2'b00};
            ifid_valid_next = 1'b0;
            ifid_pc_next    = pc_reg;
            ifid_inst_next  = NOP_INST;
            state_next      = ST_RUN;
            misalign_next   = |redirect_pc[1:0];
        end else if (stall) begin
            state_next = state_reg;
        end else if (state_reg == ST_HALT) begin
            ifid_valid_next = 1'b0;
            ifid_pc_next    = pc_reg;
            ifid_inst_next  = NOP_INST;
        end else if (imem_ready) begin
            ifid_valid_next = 1'b1;
            ifid_pc_next    = pc_reg;
            ifid_inst_next  = imem_rdata;
            pc_next         = pc_reg + 32'd4;
            fetch_load      = 1'b1;
            if (is_halt_word) begin
                state_next = ST_HALT;
            end
        end else begin
            ifid_valid_next = 1'b0;
            ifid_pc_next    = pc_reg;
            ifid_inst_next  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            pc_reg         <= RESET_PC;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= RESET_PC;
            ifid_inst_reg  <= NOP_INST;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_inst_reg  <= ifid_inst_next;
            misalign_reg   <= misalign_next;
        end
    end

    assign imem_addr  = pc_reg;
    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_inst  = ifid_inst_reg;
    assign misalign   = misalign_reg;
    assign halted     = (state_reg == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;

    // A redirect wins over stall, so such cycles are not counted as stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_reg <= 32'd0;
            stall_count_reg <= 32'd0;
        end else begin
            if (fetch_load) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (stall && !redirect_valid) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, counter sequence, random vs model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        misalign;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_inst      (ifid_inst),
        .misalign       (misalign),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: addi words tagged with the address, plus halting words by mode.
    int          mem_mode;
    logic [31:0] ecall_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode,
                                             input logic [31:0] eaddr);
        if (mode == 0) begin
            if (a == eaddr) return ECALL;
            return {a[11:0], 20'h00013};
        end
        if (((a >> 2) % 32'd13) == 32'd12) return a[2] ? EBREAK : ECALL;
        return {a[11:0], 20'h00013};
    endfunction

    assign imem_rdata = mem_word(imem_addr, mem_mode, ecall_addr);

    int vectors;
    int miscompares;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        s;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] eaddr;
        logic        emis;
        logic        ehalt;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic ev, input logic [31:0] epc,
                        input logic [31:0] einst, input logic [31:0] eaddr,
                        input logic emis, input logic ehalt);
        vec_t v;
        v.r = r; v.s = s; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.einst = einst; v.eaddr = eaddr;
        v.emis = emis; v.ehalt = ehalt;
        tbl.push_back(v);
    endtask

    task automatic check_outputs(input int idx, input logic ev, input logic [31:0] epc,
                                 input logic [31:0] einst, input logic [31:0] eaddr,
                                 input logic emis, input logic ehalt);
        chk("ifid_valid", idx, {31'b0, ifid_valid}, {31'b0, ev});
        chk("ifid_pc",    idx, ifid_pc, epc);
        chk("ifid_inst",  idx, ifid_inst, einst);
        chk("imem_addr",  idx, imem_addr, eaddr);
        chk("misalign",   idx, {31'b0, misalign}, {31'b0, emis});
        chk("halted",     idx, {31'b0, halted}, {31'b0, ehalt});
    endtask

    // Reference model state, advanced once per rising edge from the spec's rules.
    logic [31:0] m_pc, m_ipc, m_inst, m_fc, m_sc;
    logic        m_v, m_mis, m_halt;

    task automatic model_step();
        logic [31:0] w;
        w = mem_word(m_pc, mem_mode, ecall_addr);
        if (rst) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_v = 1'b0;
            m_mis = 1'b0; m_halt = 1'b0; m_fc = 0; m_sc = 0;
        end else begin
            m_mis = 1'b0;
            if (redirect_valid) begin
                m_v = 1'b0; m_inst = NOP; m_ipc = m_pc;
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_halt = 1'b0;
                m_mis = (redirect_pc % 4) != 0;
            end else if (stall) begin
                m_sc = m_sc + 1;
            end else if (m_halt || !imem_ready) begin
                m_v = 1'b0; m_inst = NOP; m_ipc = m_pc;
            end else begin
                m_v = 1'b1; m_inst = w; m_ipc = m_pc;
                m_pc = m_pc + 4;
                m_fc = m_fc + 1;
                if (w == ECALL || w == EBREAK) m_halt = 1'b1;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0;
        mem_mode = 0;
        ecall_addr = 32'h0000_001C;

        //   rst   stall  rv    rpc           rdy   | valid pc            inst          addr          mis   halt
        addv(1'b1, 1'b0, 1'b0, 32'h0,        1'b0,  1'b0, 32'h00, NOP,          32'h00, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h00, 32'h00000013, 32'h04, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h04, 32'h00400013, 32'h08, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h08, 32'h00800013, 32'h0C, 1'b0, 1'b0);
        addv(1'b0, 1'b1, 1'b0, 32'h0,        1'b1,  1'b1, 32'h08, 32'h00800013, 32'h0C, 1'b0, 1'b0);
        addv(1'b0, 1'b1, 1'b0, 32'h0,        1'b1,  1'b1, 32'h08, 32'h00800013, 32'h0C, 1'b0, 1'b0);
        addv(1'b0, 1'b1, 1'b0, 32'h0,        1'b0,  1'b1, 32'h08, 32'h00800013, 32'h0C, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h0C, 32'h00C00013, 32'h10, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b0,  1'b0, 32'h10, NOP,          32'h10, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b0,  1'b0, 32'h10, NOP,          32'h10, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h10, 32'h01000013, 32'h14, 1'b0, 1'b0);
        addv(1'b0, 1'b1, 1'b1, 32'h40,       1'b1,  1'b0, 32'h14, NOP,          32'h40, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h40, 32'h04000013, 32'h44, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 32'h42,       1'b1,  1'b0, 32'h44, NOP,          32'h40, 1'b1, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h40, 32'h04000013, 32'h44, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 32'h14,       1'b1,  1'b0, 32'h44, NOP,          32'h14, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h14, 32'h01400013, 32'h18, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h18, 32'h01800013, 32'h1C, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h1C, ECALL,        32'h20, 1'b0, 1'b1);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b0, 32'h20, NOP,          32'h20, 1'b0, 1'b1);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b0, 32'h20, NOP,          32'h20, 1'b0, 1'b1);
        addv(1'b0, 1'b1, 1'b0, 32'h0,        1'b1,  1'b0, 32'h20, NOP,          32'h20, 1'b0, 1'b1);
        addv(1'b0, 1'b0, 1'b1, 32'h20,       1'b1,  1'b0, 32'h20, NOP,          32'h20, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h20, 32'h02000013, 32'h24, 1'b0, 1'b0);
        addv(1'b1, 1'b1, 1'b1, 32'h80,       1'b1,  1'b0, 32'h00, NOP,          32'h00, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h00, 32'h00000013, 32'h04, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 32'h1C,       1'b1,  1'b0, 32'h04, NOP,          32'h1C, 1'b0, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1,  1'b1, 32'h1C, ECALL,        32'h20, 1'b0, 1'b1);
        addv(1'b1, 1'b0, 1'b0, 32'h0,        1'b1,  1'b0, 32'h00, NOP,          32'h00, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; stall = tbl[i].s; redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc; imem_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%b stall=%b rv=%b rpc=%h rdy=%b -> v=%b pc=%h inst=%h addr=%h mis=%b halt=%b",
                     i, tbl[i].r, tbl[i].s, tbl[i].rv, tbl[i].rpc, tbl[i].rdy,
                     ifid_valid, ifid_pc, ifid_inst, imem_addr, misalign, halted);
            check_outputs(i, tbl[i].ev, tbl[i].epc, tbl[i].einst, tbl[i].eaddr,
                          tbl[i].emis, tbl[i].ehalt);
        end

`ifdef FETCH_PERF_CNT_EN
        // Ten valid fetches then three stalls, then reset clears both counters.
        ecall_addr = 32'hFFFF_FFFF;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        stall = 1'b0; imem_ready = 1'b0;
        $display("perf: fetch_count=%0d stall_count=%0d", fetch_count, stall_count);
        chk("fetch_count", 1000, fetch_count, 32'd10);
        chk("stall_count", 1001, stall_count, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("perf after rst: fetch_count=%0d stall_count=%0d", fetch_count, stall_count);
        chk("fetch_count_rst", 1002, fetch_count, 32'd0);
        chk("stall_count_rst", 1003, stall_count, 32'd0);
`endif

        // Randomized run against the reference model, starting from reset.
        mem_mode = 1;
        for (int n = 0; n < 1500; n++) begin
            rst            = (n == 0) || ($urandom_range(0, 59) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            imem_ready     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                redirect_pc = 32'($urandom_range(0, 255));
            @(posedge clk);
            model_step();
            #1;
            $display("rnd %0d: rst=%b stall=%b rv=%b rpc=%h rdy=%b -> v=%b pc=%h inst=%h addr=%h mis=%b halt=%b",
                     n, rst, stall, redirect_valid, redirect_pc, imem_ready,
                     ifid_valid, ifid_pc, ifid_inst, imem_addr, misalign, halted);
            check_outputs(2000 + n, m_v, m_ipc, m_inst, m_pc, m_mis, m_halt);
`ifdef FETCH_PERF_CNT_EN
            chk("rnd_fetch_count", 2000 + n, fetch_count, m_fc);
            chk("rnd_stall_count", 2000 + n, stall_count, m_sc);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, drives the instruction-memory read port and produces the IF/ID pipeline register consumed by the decode stage. It handles stall requests from the hazard unit and branch/jump redirects from EX. On fetching ECALL/EBREAK it parks the front end, which gives the top-level simulation a clean end-of-program signal.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): instruction injected into IF/ID on bubbles and flushes.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_addr`  out  32: byte address of the current fetch; always equals `pc_q`.
- `imem_rdata`  in  32: instruction word; combinational, valid in the same cycle when `imem_ready`=1.
- `imem_ready`  in  1: memory has valid `imem_rdata` this cycle.
- `stall`  in  1: hazard unit holds IF and IF/ID.
- `redirect_valid`  in  1: taken branch/jump resolved in EX.
- `redirect_pc`  in  32: redirect target.
- `ifid_valid`  out  1: IF/ID holds a real instruction.
- `ifid_pc`  out  32: PC of `ifid_inst`.
- `ifid_inst`  out  32: fetched instruction, or `NOP_INST` when not valid.
- `misalign`  out  1: one-cycle pulse when a redirect target had bits [1:0] != 0.
- `halted`  out  1: front end is parked in HALT.
- `fetch_count`, `stall_count`  out  32 each: present only with `FETCH_PERF_CNT_EN`.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Per-cycle priority: `rst` > `redirect_valid` > `stall` > HALT > normal fetch.
- **Redirect:**
  - `pc_q` <= {`redirect_pc`[31:2], 2'b00}.
  - IF/ID flushed: `ifid_valid`=0, `ifid_inst`=`NOP_INST`, `ifid_pc`=`pc_q`.
  - State <= RUN, including from HALT, because the halting instruction was on the wrong path.
  - `misalign` <= |`redirect_pc`[1:0].
  - Redirect overrides a simultaneous `stall`.
- **Stall (no redirect):** `pc_q`, IF/ID and state hold. `imem_rdata` is ignored.
- **RUN, no stall, `imem_ready`=1:**
  - IF/ID <= {1, `pc_q`, `imem_rdata`}.
  - `pc_q` <= `pc_q` + 4, wrapping modulo 2^32.
  - If `imem_rdata` is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK): that word still enters IF/ID valid, and state <= HALT.
- **RUN, no stall, `imem_ready`=0:** bubble into IF/ID (valid 0, `NOP_INST`, `ifid_pc`=`pc_q`). `pc_q` holds.
- **HALT, no stall/redirect:** `pc_q` holds; IF/ID <= bubble every cycle; `imem_addr` stays at the PC after the halting instruction. Only `rst` or a redirect exits.
- `halted` = (state == HALT), registered.

## Timing
- Reset values:
  - `pc_q`/`imem_addr` = `RESET_PC`.
  - `ifid_valid`=0, `ifid_inst`=`NOP_INST`, `ifid_pc`=`RESET_PC`.
  - `misalign`=0, `halted`=0, counters=0.
- Fetch latency: the word at `imem_addr` in cycle N appears on `ifid_*` after edge N+1 when ready and not stalled.
- Throughput: one instruction per cycle while `imem_ready`=1 and no stall.
- Redirect penalty: the redirect is sampled at edge N. The target address is presented in cycle N+1 and reaches IF/ID at edge N+2. Exactly one flushed slot is visible at IF/ID.
- `halted` rises at the same edge the ECALL/EBREAK enters IF/ID.
- `misalign` is high for exactly one cycle.
- `rst` asserted mid-operation (stalled, halted or waiting) restores all reset values at the next edge, regardless of other inputs.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every edge that loads a valid instruction into IF/ID.
  - `stall_count` increments on every edge with `stall`=1 and `redirect_valid`=0.
  - Both are 32-bit, wrap to 0, and clear on `rst`.
- Not defined: both ports and all counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, `imem_ready`=1, memory returns `addi` words -> `ifid_pc` = 0, 4, 8, 12 on consecutive cycles, `ifid_valid`=1 from the first edge after reset.
- `stall`=1 for 3 cycles while IF/ID holds PC 8 -> `ifid_pc` stays 8 and `imem_addr` stays 12 for 3 cycles, then resumes with 12.
- `redirect_valid`=1 with `redirect_pc`=0x40 together with `stall`=1 -> next cycle `ifid_valid`=0, `ifid_inst`=0x13 and `imem_addr`=0x40; the following edge gives `ifid_pc`=0x40. Repeat with 0x42 -> `misalign` pulses and fetch goes to 0x40.
- `imem_ready` low 2 cycles at PC 0x10 -> two bubbles, PC holds 0x10, then `ifid_pc`=0x10 valid.
- ECALL at 0x1C -> `ifid_inst`=0x73 valid and `halted`=1 at the same edge, then only bubbles. Redirect to 0x20 -> `halted`=0 and fetch resumes at 0x20.
- With `FETCH_PERF_CNT_EN`: 10 valid fetches and 3 stalls -> `fetch_count`=10, `stall_count`=3. Then `rst` -> both 0.
